sevenseg_scan_arbiter: RTL
==========================

Name: sevenseg_scan_arbiter

Overview:
- Drives the board's 8-digit, common-anode seven-segment display and shares it among three requesters:
  - src0: debug/register value (default owner).
  - src1: program-memory address shown in prog mode.
  - src2: UART byte/status word.
- Generates its own scan timing from clk; no derived display clock is needed.
- Arbitrates ownership only at frame boundaries and latches a coherent 32-bit snapshot per frame.
- Optionally blanks leading zeros.

Parameters:
- SCAN_DIV, 1000, clk cycles per digit slot; legal range 2..2^20.
- HOLD_FRAMES, 4, minimum number of complete frames a granted requester keeps the display while still requesting; legal range 1..255.

Ports:
- clk, input, 1, system clock.
- Rst, input, 1, synchronous active-high reset.
- req, input, 3, per-source display request; bit i belongs to src i.
- data0, input, 32, src0 value, 8 hex nibbles.
- data1, input, 32, src1 value.
- data2, input, 32, src2 value.
- blank_lz, input, 1, 1 = blank leading-zero digits.
- an, output, 8, digit enables, active-low, one-hot-low; digit 0 = an[0].
- sev_out, output, 7, segments, active-low, registered.
- grant, output, 3, one-hot current owner.
- frame_done, output, 1, one-cycle pulse at each frame end.

Behaviour:
- Reset and control:
  - Rst is synchronous and active-high; clock is clk.
  - On reset, all state returns to these values on the next cycle, including when reset is asserted mid-frame:
    - prescaler = 0, digit index = 0, hold counter = 0.
    - snapshot = 0, grant = 3'b001.
    - an = 8'hFE, sev_out = 7'b0000001 (glyph '0'), frame_done = 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - tick is 1 on the cycle the count equals SCAN_DIV-1.
- Digit index:
  - 3-bit, advances on tick, wraps 7 -> 0.
  - an and sev_out update on the cycle after tick, together; they must never be skewed.
- Frame boundary (tick while index = 7):
  - frame_done = 1 for exactly that cycle.
  - Hold counter increments, saturating at HOLD_FRAMES.
  - Arbitration runs; see below.
  - snapshot <= data of the new grant.
  - The first digit of the new frame (index 0) shows the new snapshot.
- Arbitration, evaluated only at a frame boundary:
  - Candidate = highest-priority asserted req. Priority order: src1 > src2 > src0.
  - If no req is asserted, the candidate is src0.
  - grant switches to the candidate only if one of these holds:
    - the current owner's req is low, or
    - hold counter >= HOLD_FRAMES.
  - Otherwise grant is unchanged.
  - When grant changes, the hold counter resets to 0.
  - grant is never zero and never multi-hot.
- Snapshot:
  - Changes on data0..2 or on req have no effect on the frame in progress.
- Segment encoding (abcdefg, bit6 = a), nibble -> sev_out:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
- Leading-zero blanking (blank_lz = 1):
  - Let m = index of the most significant non-zero nibble of the snapshot; m = 0 if the snapshot is 0.
  - Digit slots with index > m drive an = 8'hFF and sev_out = 7'b1111111.
  - Digit 0 is always displayed.
  - blank_lz is sampled per digit slot.
- Tick timing:
  - After Rst deasserts, the first tick occurs SCAN_DIV cycles later.
  - A full frame is 8*SCAN_DIV cycles.
- Simultaneous events:
  - Rst asserted together with a tick: Rst wins.
  - req rising on the boundary cycle: it is sampled on that same cycle.

Test Plan:
1. SCAN_DIV=4, Rst pulse, req=0, data0=32'h12345678.
   - During the first frame: an sequences FE, FD, FB, ... 7F, each held 4 cycles, all glyphs '0'.
   - frame_done pulses once.
   - Second frame: digit0 = 0000000 ('8'), digit1 = 0001111 ('7'), digit7 = 1001111 ('1').
2. req=3'b110 asserted before a boundary, current grant = 001.
   - At the boundary grant = 010.
   - The next frame shows data1.
3. HOLD_FRAMES=4, grant = src2 (req[2] held), req[1] asserted mid-frame.
   - grant stays 100 for 4 completed frames, then becomes 010.
   - Variant: dropping req[2] instead causes the switch at the very next boundary.
4. blank_lz=1, snapshot 32'h000000A5.
   - Digits 2..7: an = FF, sev_out = 1111111.
   - Digit0 = 0100100, digit1 = 0001000.
   - Snapshot 0: only digit0 lit, showing 0000001.
5. data0 changes from 32'h11111111 to 32'h22222222 during digit 3 of a frame.
   - The remaining digits of that frame show '1'.
   - The next frame shows '2'.
6. Rst asserted during digit 5 with grant = 010.
   - Next cycle: an = FE, sev_out = 0000001, grant = 001, frame_done = 0.
   - First tick occurs SCAN_DIV cycles after release.

Source files
------------

// File: rtl/sevenseg_scan_arbiter.sv
// sevenseg_scan_arbiter: scans an 8-digit common-anode seven-segment display
// and shares it among three requesters, switching owner only at frame ends.
// Ports: clk/Rst (sync, active-high); req[2:0] per-source request; data0..2
// 32-bit hex values; blank_lz blanks leading zeros; an[7:0] digit enables
// (active-low); sev_out[6:0] segments abcdefg (active-low, registered);
// grant[2:0] one-hot owner; frame_done one-cycle pulse on the frame's last cycle.
module sevenseg_scan_arbiter #(
  parameter int SCAN_DIV    = 1000,
  parameter int HOLD_FRAMES = 4
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic [2:0]  req,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [6:0]  sev_out,
  output logic [2:0]  grant,
  output logic        frame_done
);

  localparam int            CW       = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] DIV_MAX  = CW'(SCAN_DIV - 1);
  localparam logic [7:0]    HOLD_MAX = 8'(HOLD_FRAMES);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    hold;
  logic [31:0]   snap;

  logic          tick;
  logic          boundary;
  logic [2:0]    cand;
  logic [2:0]    grant_nxt;
  logic [7:0]    hold_inc;
  logic [7:0]    hold_nxt;
  logic [31:0]   snap_nxt;
  logic [31:0]   disp_snap;
  logic [2:0]    idx_nxt;
  logic [2:0]    msd;
  logic [3:0]    nibble;
  logic          blank;
  logic [7:0]    an_nxt;
  logic [6:0]    sev_nxt;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
  endfunction

  assign tick       = (cnt == DIV_MAX);
  assign boundary   = tick && (idx == 3'd7);
  assign frame_done = boundary && !Rst;

  // Arbitration. The hold count used for the switch decision already
  // includes the frame that is ending now, so a holder keeps the display
  // for exactly HOLD_FRAMES completed frames before it can be pre-empted.
  always_comb begin
    cand      = 3'b001;
    grant_nxt = grant;
    hold_inc  = (hold == HOLD_MAX) ? HOLD_MAX : hold + 8'd1;
    if (req[1])      cand = 3'b010;
    else if (req[2]) cand = 3'b100;
    if (((req & grant) == 3'b000) || (hold_inc == HOLD_MAX))
      grant_nxt = cand;
    hold_nxt = (grant_nxt != grant) ? 8'd0 : hold_inc;
    case (grant_nxt)
      3'b010:  snap_nxt = data1;
      3'b100:  snap_nxt = data2;
      default: snap_nxt = data0;
    endcase
  end

  // Next-slot display. On a frame boundary digit 0 must already come from
  // the snapshot being latched on this same edge, hence the bypass.
  always_comb begin
    disp_snap = boundary ? snap_nxt : snap;
    idx_nxt   = idx + 3'd1;
    msd       = 3'd0;
    for (int i = 0; i < 8; i++)
      if (disp_snap[4*i +: 4] != 4'h0) msd = 3'(i);
    nibble  = disp_snap[{idx_nxt, 2'b00} +: 4];
    blank   = blank_lz && (idx_nxt > msd);
    an_nxt  = blank ? 8'hFF : ~(8'd1 << idx_nxt);
    sev_nxt = blank ? 7'b1111111 : seg(nibble);
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      cnt     <= '0;
      idx     <= 3'd0;
      hold    <= 8'd0;
      snap    <= 32'd0;
      grant   <= 3'b001;
      an      <= 8'hFE;
      sev_out <= 7'b0000001;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        idx     <= idx_nxt;
        an      <= an_nxt;
        sev_out <= sev_nxt;
      end
      if (boundary) begin
        grant <= grant_nxt;
        hold  <= hold_nxt;
        snap  <= snap_nxt;
      end
    end
  end

endmodule
